// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keyer: symbol codes, FSM state type and helpers.
package morse_pkg;

  localparam logic [2:0] SYM_DOT  = 3'b001;
  localparam logic [2:0] SYM_DASH = 3'b010;
  localparam logic [2:0] SYM_CHAR = 3'b011;
  localparam logic [2:0] SYM_WORD = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    GAP   = 2'd2,
    SPACE = 2'd3
  } state_t;

  function automatic logic is_valid_sym(input logic [2:0] code);
    return (code == SYM_DOT) || (code == SYM_DASH) ||
           (code == SYM_CHAR) || (code == SYM_WORD);
  endfunction

  // Largest element length in units; sizes the unit counter.
  function automatic int max_units(input int a, input int b, input int c, input int d);
    int m;
    m = 1;
    if (a > m) m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/morse_keyer_if.sv
// Symbol input channel of the Morse keyer.
// A symbol transfers on every clk edge where sym_valid && sym_ready; sym_ready never depends on sym_valid.
interface morse_keyer_if;
  logic       sym_valid;
  logic [2:0] sym_code;
  logic       sym_ready;

  modport master (output sym_valid, output sym_code, input sym_ready);
  modport slave  (input sym_valid, input sym_code, output sym_ready);
endinterface

// File: rtl/morse_unit_timer.sv
// Element timer: a prescaler of UNIT_CYCLES cycles per unit and a down-counting unit counter.
// o_final marks the last cycle of the loaded element.
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 1000,
  parameter int UW          = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [UW-1:0] i_units,
  output logic          o_final
);

  localparam int PW = $clog2(UNIT_CYCLES + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(UNIT_CYCLES - 1);

  logic [PW-1:0] r_pre;
  logic [UW-1:0] r_units;
  logic          w_unit_end;

  assign w_unit_end = (r_pre == PRE_LAST);
  assign o_final    = w_unit_end && (r_units == UW'(1));

  // Counting stops once the unit counter reaches zero, so nothing wraps inside an element.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre   <= '0;
      r_units <= '0;
    end else if (i_load) begin
      r_pre   <= '0;
      r_units <= i_units;
    end else if (r_units != '0) begin
      if (w_unit_end) begin
        r_pre   <= '0;
        r_units <= r_units - UW'(1);
      end else begin
        r_pre <= r_pre + PW'(1);
      end
    end
  end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer top: turns dot/dash/char/word symbols into a timed key waveform.
// Optional sidetone generator enabled by defining MORSE_KEYER_SIDETONE_EN.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 1000,
  parameter int DASH_UNITS  = 3,
  parameter int GAP_UNITS   = 1,
  parameter int CHAR_UNITS  = 2,
  parameter int WORD_UNITS  = 6,
  parameter int TONE_HALF   = 8
) (
  input  logic          clk,
  input  logic          rst,
  morse_keyer_if.slave  sym,
  output logic          key,
  output logic [2:0]    cur_code,
  output logic          busy,
  output logic          err,
  output logic          tone,
  output state_t        o_dbg_state
);

  localparam int MAX_U = max_units(DASH_UNITS, GAP_UNITS, CHAR_UNITS, WORD_UNITS);
  localparam int UW    = $clog2(MAX_U + 1);

  state_t        r_state;
  logic          r_key;
  logic [2:0]    r_cur;
  logic          r_err;

  logic          w_final;
  logic          w_ready;
  logic          w_accept;
  logic          w_load;
  logic [UW-1:0] w_load_units;

  assign w_ready  = (r_state == IDLE) ||
                    (((r_state == GAP) || (r_state == SPACE)) && w_final);
  assign w_accept = sym.sym_valid && w_ready;

  // Timer reload: element length of an accepted symbol, or the trailing gap after a mark.
  always_comb begin
    w_load       = 1'b0;
    w_load_units = '0;
    if (w_accept) begin
      case (sym.sym_code)
        SYM_DOT:  begin w_load = 1'b1; w_load_units = UW'(1);          end
        SYM_DASH: begin w_load = 1'b1; w_load_units = UW'(DASH_UNITS); end
        SYM_CHAR: begin w_load = 1'b1; w_load_units = UW'(CHAR_UNITS); end
        SYM_WORD: begin w_load = 1'b1; w_load_units = UW'(WORD_UNITS); end
        default:  begin w_load = 1'b0; w_load_units = '0;              end
      endcase
    end else if ((r_state == MARK) && w_final) begin
      w_load       = 1'b1;
      w_load_units = UW'(GAP_UNITS);
    end
  end

  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES),
    .UW          (UW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_units (w_load_units),
    .o_final (w_final)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_key   <= 1'b0;
      r_cur   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        MARK: begin
          if (w_final) begin
            r_state <= GAP;
            r_key   <= 1'b0;
            r_cur   <= '0;
          end
        end
        default: begin
          if (w_accept) begin
            if (is_valid_sym(sym.sym_code)) begin
              r_cur <= sym.sym_code;
              if ((sym.sym_code == SYM_DOT) || (sym.sym_code == SYM_DASH)) begin
                r_state <= MARK;
                r_key   <= 1'b1;
              end else begin
                r_state <= SPACE;
              end
            end else begin
              // Invalid codes are swallowed; the keyer drops back to idle.
              r_err   <= 1'b1;
              r_state <= IDLE;
              r_cur   <= '0;
            end
          end else if ((r_state != IDLE) && w_final) begin
            r_state <= IDLE;
            r_cur   <= '0;
          end
        end
      endcase
    end
  end

  assign sym.sym_ready = w_ready;
  assign key           = r_key;
  assign cur_code      = r_cur;
  assign busy          = (r_state != IDLE);
  assign err           = r_err;
  assign o_dbg_state   = r_state;

`ifdef MORSE_KEYER_SIDETONE_EN
  localparam int TW = $clog2(TONE_HALF + 1);

  logic [TW-1:0] r_tdiv;
  logic          r_tone;

  // Divider idles cleared while the key is up, so each mark starts with tone low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tdiv <= '0;
      r_tone <= 1'b0;
    end else if (!r_key) begin
      r_tdiv <= '0;
      r_tone <= 1'b0;
    end else if (r_tdiv == TW'(TONE_HALF - 1)) begin
      r_tdiv <= '0;
      r_tone <= ~r_tone;
    end else begin
      r_tdiv <= r_tdiv + TW'(1);
    end
  end

  assign tone = r_tone & r_key;
`else
  assign tone = 1'b0;
`endif

endmodule
